// File: rtl/clk_tree_monitor.sv
// Period monitor for the divided clock bus. It measures the selected divided clock
// in clk cycles and reports the period with mismatch, timeout and illegal-select flags.
module clk_tree_monitor #(
   parameter int TIMEOUT = 131072
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic [16:0] f_in,
   input  logic [4:0]  sel,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [17:0] period,
   output logic        mismatch,
   output logic        err_timeout,
   output logic        err_sel
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETTLE  = 3'd1;
   localparam logic [2:0] ST_ARM     = 3'd2;
   localparam logic [2:0] ST_MEASURE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [17:0] CNT_LAST    = 18'(TIMEOUT - 1);
   localparam logic [17:0] SETTLE_LAST = 18'd2;

   logic [2:0]  state;
   logic [17:0] cnt;
   logic [4:0]  sel_q;
   logic        s1;
   logic        s2;
   logic        s3;
   logic        rise;
   logic        sel_ok;
   logic [17:0] expected;

   assign sel_ok   = (sel != 5'd0) && (sel <= 5'd16);
   assign rise     = s2 & ~s3;
   assign expected = 18'd1 << sel_q;

   // Two-flop synchroniser on the muxed divided clock plus a history flop for edge detect.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= f_in[sel_q];
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Measurement FSM; cnt doubles as settle counter, watchdog and period counter.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state       <= ST_IDLE;
         cnt         <= 18'd0;
         sel_q       <= 5'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         period      <= 18'd0;
         mismatch    <= 1'b0;
         err_timeout <= 1'b0;
         err_sel     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  period      <= 18'd0;
                  mismatch    <= 1'b0;
                  err_timeout <= 1'b0;
                  cnt         <= 18'd0;
                  if (sel_ok) begin
                     sel_q   <= sel;
                     busy    <= 1'b1;
                     err_sel <= 1'b0;
                     state   <= ST_SETTLE;
                  end else begin
                     err_sel <= 1'b1;
                     done    <= 1'b1;
                     state   <= ST_DONE;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            // Edges seen here may stem from the mux switch, so they are discarded.
            ST_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt   <= 18'd0;
                  state <= ST_ARM;
               end else begin
                  cnt <= cnt + 18'd1;
               end
            end
            ST_ARM: begin
               if (rise) begin
                  cnt   <= 18'd1;
                  state <= ST_MEASURE;
               end else if (cnt == CNT_LAST) begin
                  err_timeout <= 1'b1;
                  done        <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  cnt <= cnt + 18'd1;
               end
            end
            ST_MEASURE: begin
               if (rise) begin
                  period   <= cnt;
                  mismatch <= (cnt != expected);
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end else if (cnt == CNT_LAST) begin
                  period      <= cnt;
                  err_timeout <= 1'b1;
                  done        <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  cnt <= cnt + 18'd1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_tree_monitor.sv
// Directed self-checking bench for clk_tree_monitor driven by a counter-based
// model of the clock tree with stuck-low and wrong-frequency fault injection.
module tb_clk_tree_monitor;

   localparam int TMO = 512;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic [16:0] f_in;
   logic [4:0]  sel = 5'd0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [17:0] period;
   logic        mismatch;
   logic        err_timeout;
   logic        err_sel;

   logic [15:0] div_cnt = 16'd0;
   logic        stuck3 = 1'b0;
   logic        fast2 = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   clk_tree_monitor #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rstb(rstb), .f_in(f_in), .sel(sel), .start(start),
      .busy(busy), .done(done), .period(period), .mismatch(mismatch),
      .err_timeout(err_timeout), .err_sel(err_sel)
   );

   always #5 clk = ~clk;

   // Ripple divider model: bit i of f_in toggles at fclk/2^i.
   always_ff @(posedge clk) div_cnt <= div_cnt + 16'd1;

   assign f_in = {div_cnt[15:3], (stuck3 ? 1'b0 : div_cnt[2]),
                  (fast2 ? div_cnt[2] : div_cnt[1]), div_cnt[0], clk};

   task automatic pulse_start(input logic [4:0] s);
      @(negedge clk);
      sel   = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
      cyc  = 1;
      seen = done;
      while (!seen && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         seen = done;
      end
   endtask

   task automatic test_reset;
      rstb = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp += 6;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      if (period !== 18'd0) begin n_bad++; $display("FAIL reset_period got %0d want 0", period); end
      if (mismatch !== 1'b0) begin n_bad++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
      if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_tmo got %b want 0", err_timeout); end
      if (err_sel !== 1'b0) begin n_bad++; $display("FAIL reset_errsel got %b want 0", err_sel); end
      rstb = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_illegal_sel(input logic [4:0] s);
      pulse_start(s);
      n_cmp += 6;
      if (done !== 1'b1) begin n_bad++; $display("FAIL ill_done sel=%0d got %b want 1", s, done); end
      if (err_sel !== 1'b1) begin n_bad++; $display("FAIL ill_errsel sel=%0d got %b want 1", s, err_sel); end
      if (period !== 18'd0) begin n_bad++; $display("FAIL ill_period sel=%0d got %0d want 0", s, period); end
      if (mismatch !== 1'b0) begin n_bad++; $display("FAIL ill_mismatch sel=%0d got %b want 0", s, mismatch); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL ill_busy sel=%0d got %b want 0", s, busy); end
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL ill_after sel=%0d done=%b busy=%b want 0 0", s, done, busy);
      end
   endtask

   task automatic test_healthy(input logic [4:0] s, input bit change_sel);
      int cyc;
      bit seen;
      int lim;
      lim = 4 + 2 * (1 << s) + 2;
      pulse_start(s);
      n_cmp += 1;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL ok_busy sel=%0d got %b want 1", s, busy); end
      if (change_sel) sel = 5'd1;
      wait_done(lim + 10, cyc, seen);
      n_cmp += 6;
      if (!seen) begin n_bad++; $display("FAIL ok_nodone sel=%0d got none want done", s); end
      if (period !== 18'(1 << s)) begin n_bad++; $display("FAIL ok_period sel=%0d got %0d want %0d", s, period, 1 << s); end
      if (mismatch !== 1'b0) begin n_bad++; $display("FAIL ok_mismatch sel=%0d got %b want 0", s, mismatch); end
      if (err_timeout !== 1'b0 || err_sel !== 1'b0) begin
         n_bad++; $display("FAIL ok_flags sel=%0d got tmo=%b sel=%b want 0 0", s, err_timeout, err_sel);
      end
      if (cyc > lim) begin n_bad++; $display("FAIL ok_latency sel=%0d got %0d want <=%0d", s, cyc, lim); end
      @(negedge clk);
      if (done !== 1'b0) begin n_bad++; $display("FAIL ok_pulse sel=%0d got %b want 0", s, done); end
      @(negedge clk);
      n_cmp += 1;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL ok_idle sel=%0d got %b want 0", s, busy); end
   endtask

   task automatic test_timeout;
      int cyc;
      bit seen;
      stuck3 = 1'b1;
      pulse_start(5'd3);
      wait_done(TMO + 20, cyc, seen);
      n_cmp += 5;
      if (!seen) begin n_bad++; $display("FAIL tmo_nodone got none want done"); end
      if (cyc != TMO + 4) begin n_bad++; $display("FAIL tmo_latency got %0d want %0d", cyc, TMO + 4); end
      if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_flag got %b want 1", err_timeout); end
      if (mismatch !== 1'b0) begin n_bad++; $display("FAIL tmo_mismatch got %b want 0", mismatch); end
      if (period !== 18'd0) begin n_bad++; $display("FAIL tmo_period got %0d want 0", period); end
      stuck3 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int ndone;
      int p_seen;
      bit m_seen;
      ndone  = 0;
      p_seen = 0;
      m_seen = 1'b0;
      fast2  = 1'b1;
      pulse_start(5'd2);
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (done === 1'b1) begin
            ndone++;
            p_seen = int'(period);
            m_seen = mismatch;
         end
         @(negedge clk);
      end
      n_cmp += 3;
      if (ndone != 1) begin n_bad++; $display("FAIL b2b_count got %0d want 1", ndone); end
      if (p_seen != 8) begin n_bad++; $display("FAIL b2b_period got %0d want 8", p_seen); end
      if (m_seen !== 1'b1) begin n_bad++; $display("FAIL b2b_mismatch got %b want 1", m_seen); end
      fast2 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_midop;
      bit prev;
      bit got_done;
      int guard;
      pulse_start(5'd5);
      repeat (4) @(negedge clk);
      prev  = f_in[5];
      guard = 0;
      while (!(f_in[5] && !prev) && guard < 80) begin
         prev = f_in[5];
         @(negedge clk);
         guard++;
      end
      n_cmp += 1;
      if (guard >= 80) begin n_bad++; $display("FAIL mid_noedge got timeout want f_in[5] rise"); end
      repeat (10) @(negedge clk);
      rstb = 1'b0;
      #1;
      n_cmp += 1;
      if ({busy, done, period, mismatch, err_timeout, err_sel} !== 23'd0) begin
         n_bad++; $display("FAIL mid_clear got busy=%b done=%b period=%0d want all 0", busy, done, period);
      end
      got_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) got_done = 1'b1;
      end
      rstb = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) got_done = 1'b1;
      end
      n_cmp += 1;
      if (got_done) begin n_bad++; $display("FAIL mid_stale got activity want idle"); end
      test_healthy(5'd5, 1'b0);
   endtask

   initial begin
      test_reset();
      test_healthy(5'd1, 1'b0);
      test_healthy(5'd4, 1'b1);
      test_healthy(5'd8, 1'b0);
      test_illegal_sel(5'd0);
      test_illegal_sel(5'd20);
      test_illegal_sel(5'd17);
      test_timeout();
      test_back_to_back();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_tree_monitor.md
# clk_tree_monitor

Self-checking period monitor for the divided clock bus produced by the clock tree. On a `start` request it selects one divided clock `f_in[sel]` and synchronises it into the `clk` domain, where `clk` is the tree's undivided `f_out[0]`. It then measures the period of the selected clock in `clk` cycles and reports the result together with mismatch, timeout and illegal-select flags. It is used at bring-up and in simulation to confirm every divider stage runs at exactly fclk/2^sel after reset release.

## Interface
Parameters:
- `TIMEOUT`, default 131072: watchdog limit in `clk` cycles, applied per wait phase; must fit in 18 bits.

Ports:
- `clk` input 1: measurement clock, connected to `f_out[0]`.
- `rstb` input 1: asynchronous, active-low reset.
- `f_in` input 17: divided clock bus; bit i nominally runs at fclk/2^i.
- `sel` input 5: index of the clock to measure; legal range 1..16.
- `start` input 1: single-cycle request; sampled only in IDLE.
- `busy` output 1: high from the cycle after an accepted `start` until DONE exits.
- `done` output 1: one-cycle completion pulse.
- `period` output 18: measured period in `clk` cycles.
- `mismatch` output 1: `period` is not equal to 2^sel.
- `err_timeout` output 1: the watchdog expired.
- `err_sel` output 1: `sel` was 0 or greater than 16.

## Operation
- `sel` is latched into `sel_q` when `start` is accepted. The mux output `f_in[sel_q]` drives a 2-flop synchroniser (s1, s2) followed by a history flop s3.
- Edge detect: `edge = s2 & ~s3`.
- A single 18-bit counter `cnt` serves both the watchdog and the period measurement.
- FSM states:
  - IDLE: `busy=0`. On `start`:
    - illegal `sel` → DONE with `err_sel=1`, `period=0`.
    - legal `sel` → clear all result outputs, `cnt=0`, go to SETTLE.
  - SETTLE: 3 cycles to flush the synchroniser after the mux change. Edges are ignored. Then `cnt=0`, go to ARM.
  - ARM: waits for the first `edge`.
    - On `edge` → `cnt=1`, go to MEASURE.
    - Otherwise `cnt++`; when `cnt==TIMEOUT-1` → `err_timeout=1`, go to DONE.
  - MEASURE:
    - On `edge` → `period=cnt`, `mismatch=(cnt != 1<<sel_q)`, go to DONE.
    - Otherwise `cnt++`; on `cnt==TIMEOUT-1` → `err_timeout=1`, `period=cnt`, go to DONE.
  - DONE: `done=1` for exactly one cycle, then IDLE.
- Edges that are N cycles apart produce `period=N`. The synchroniser latency cancels out.
- Arithmetic is unsigned 18-bit with no wrap: the timeout always fires before overflow.
- `start` while `busy` is ignored; no queueing.
- `sel` changes after acceptance have no effect until the next `start`.
- Result outputs hold their values until the next accepted `start`.
- An `err_sel` or `err_timeout` result forces `mismatch=0`.

## Timing
- Reset values: `busy=0`, `done=0`, `period=0`, `mismatch=0`, `err_timeout=0`, `err_sel=0`. FSM = IDLE, `cnt=0`, s1/s2/s3 = 0.
- Asserting `rstb` mid-operation returns to IDLE immediately. No `done` is issued and results are cleared.
- Illegal `sel`: `done` is high in cycle t+1, where `start` was sampled in cycle t. `busy` stays 0.
- Legal `sel`: `busy` rises in t+1. First `edge` eligibility is in t+4 (after SETTLE).
- `done` follows the second counted edge by 1 cycle. `period` and flags are valid in the same cycle as `done`.
- Worst-case latency for a healthy clock is 4 + 2·2^sel + 2 cycles.
- The synchroniser is mandatory because divider outputs carry clock-to-q skew relative to `clk`. A clock that is already high when selected must not count as an edge; SETTLE guarantees this.

## Test plan
- Healthy tree: `rst_ext` pulse, then `start` with `sel=1` → `done`, `period=2`, `mismatch=0`. Repeat with `sel=4` → `period=16`.
- `sel=16` on a running tree → `period=65536`, `mismatch=0`, `busy` high for at most 131078 cycles.
- `sel=0` and `sel=20` → `done` 1 cycle after `start`, `err_sel=1`, `period=0`, `busy` never high.
- `f_in[3]` forced stuck low, `sel=3` → `err_timeout=1`, `done` exactly `TIMEOUT`+4 cycles after `start`.
- `f_in[2]` replaced by fclk/8, `sel=2` → `period=8`, `mismatch=1`. A second `start` pulsed while `busy` → ignored, exactly one `done`.
- `rstb` low during MEASURE with `sel=5` → all outputs 0, FSM in IDLE, no `done`. A fresh `start` after release → `period=32`.
